hazard_unit_mc: RTL and testbench

Parametrised successor hazard unit for the 5-stage RISC-V pipeline. Keeps M/W operand forwarding and load-use detection. Adds multi-cycle load latency, for BRAM with MEM_LAT ≥ 1, and a multi-cycle mul/div unit in E driven by a start/busy FSM. Drives all stall, flush and bubble controls so that no stage duplicates or drops an instruction.

---
 rtl/hazard_pkg.sv | 38 +++
 rtl/mc_counter.sv | 29 ++
 rtl/hazard_unit_mc.sv | 168 ++++++++++++++++
 tb/tb_hazard_unit_mc.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the multi-cycle hazard unit: forward encodings,
// FSM state types, counter widths and legal latency ranges.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_e;

  typedef enum logic {
    L_IDLE = 1'b0,
    L_WAIT = 1'b1
  } ld_state_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  localparam int LCNT_W = 4;
  localparam int MCNT_W = 6;

  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 15;
  localparam int MD_LAT_MIN  = 2;
  localparam int MD_LAT_MAX  = 63;

  // Out-of-range latencies are pinned to the nearest legal value so the
  // counters can never be loaded with something they cannot represent.
  function automatic int clamp_lat(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/mc_counter.sv
// Loadable down-counter with a zero flag; paces the load-wait and mul/div FSMs.
module mc_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  // NOTE: sequential state is always written with <= so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/hazard_unit_mc.sv
// Hazard unit for the 5-stage pipeline with multi-cycle loads in M and a
// multi-cycle mul/div in E; produces forwarding, stall, flush and bubble controls.
module hazard_unit_mc
  import hazard_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int MEM_LAT = 1,
  parameter int MD_LAT  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              ResultSrcE,
  input  logic              ResultSrcM,
  input  logic              MdStartE,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              PcSrcE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              stallF,
  output logic              stallD,
  output logic              stallE,
  output logic              stallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              BubbleM,
  output logic              BubbleW,
  output logic              MdBusy
);

  localparam int MEM_LAT_EFF     = clamp_lat(MEM_LAT, MEM_LAT_MIN, MEM_LAT_MAX);
  localparam int MD_LAT_EFF      = clamp_lat(MD_LAT, MD_LAT_MIN, MD_LAT_MAX);
  localparam bit MULTI_CYCLE_MEM = (MEM_LAT_EFF > 1);

  // The entry cycle of each FSM already counts as one cycle, hence the -2.
  localparam logic [LCNT_W-1:0] LCNT_INIT = LCNT_W'(MULTI_CYCLE_MEM ? MEM_LAT_EFF - 2 : 0);
  localparam logic [MCNT_W-1:0] MCNT_INIT = MCNT_W'(MD_LAT_EFF - 2);

  ld_state_e ld_state, ld_state_nx;
  md_state_e md_state, md_state_nx;

  logic lcnt_load, lcnt_dec, lcnt_zero;
  logic mcnt_load, mcnt_dec, mcnt_zero;
  logic ld_stall, md_stall;
  logic lwstall_d, lwstall_e;
  logic br;

  function automatic fwd_e fwd_sel(
    input logic [REG_AW-1:0] rs,
    input logic [REG_AW-1:0] rd_m,
    input logic [REG_AW-1:0] rd_w,
    input logic              wr_m,
    input logic              load_m,
    input logic              wr_w
  );
    // A load in M has no data yet, so it must not be forwarded from M.
    if (wr_m && !load_m && (rs != '0) && (rs == rd_m)) return FWD_M;
    if (wr_w && (rs != '0) && (rs == rd_w))            return FWD_W;
    return FWD_RF;
  endfunction

  assign ForwardAE = fwd_sel(Rs1E, RdM, RdW, RegWriteM, ResultSrcM, RegWriteW);
  assign ForwardBE = fwd_sel(Rs2E, RdM, RdW, RegWriteM, ResultSrcM, RegWriteW);

  assign lwstall_d = (ResultSrcE && RegWriteE && (RdE != '0) && ((Rs1D == RdE) || (Rs2D == RdE)))
                  || (ResultSrcM && RegWriteM && (RdM != '0) && ((Rs1D == RdM) || (Rs2D == RdM)));
  assign lwstall_e = ResultSrcM && RegWriteM && (RdM != '0) && ((Rs1E == RdM) || (Rs2E == RdM));

  // The last WAIT cycle (counter at zero) is the load's final cycle in M and lets it go.
  assign ld_stall = (ld_state == L_IDLE) ? (ResultSrcM && MULTI_CYCLE_MEM) : !lcnt_zero;
  assign md_stall = (md_state == MD_IDLE) ? MdStartE : (md_state == MD_BUSY);

  assign stallM = ld_stall;
  assign stallE = stallM || md_stall || lwstall_e;
  assign stallD = stallE || lwstall_d;
  assign stallF = stallD;

  assign BubbleW = stallM;
  assign BubbleM = stallE && !stallM;

  assign br     = PcSrcE && !stallE;
  assign FlushD = br;
  assign FlushE = br || (stallD && !stallE);

  // Busy covers the start cycle as well, so it frames the whole sequence.
  assign MdBusy = (md_state != MD_IDLE) || md_stall;

  // NOTE: every output of a combinational block gets a default before the case,
  // so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    ld_state_nx = ld_state;
    lcnt_load   = 1'b0;
    lcnt_dec    = 1'b0;
    case (ld_state)
      L_IDLE: begin
        if (ResultSrcM && MULTI_CYCLE_MEM) begin
          ld_state_nx = L_WAIT;
          lcnt_load   = 1'b1;
        end
      end
      L_WAIT: begin
        if (lcnt_zero) ld_state_nx = L_IDLE;
        else           lcnt_dec    = 1'b1;
      end
      default: ld_state_nx = L_IDLE;
    endcase
  end

  always_comb begin
    md_state_nx = md_state;
    mcnt_load   = 1'b0;
    mcnt_dec    = 1'b0;
    case (md_state)
      MD_IDLE: begin
        if (MdStartE) begin
          md_state_nx = MD_BUSY;
          mcnt_load   = 1'b1;
        end
      end
      MD_BUSY: begin
        if (mcnt_zero) md_state_nx = MD_DONE;
        else           mcnt_dec    = 1'b1;
      end
      MD_DONE: begin
        // The same instruction still shows MdStartE here; only leaving E ends it.
        if (!stallE) md_state_nx = MD_IDLE;
      end
      default: md_state_nx = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ld_state <= L_IDLE;
      md_state <= MD_IDLE;
    end else begin
      ld_state <= ld_state_nx;
      md_state <= md_state_nx;
    end
  end

  mc_counter #(.W(LCNT_W)) u_lcnt (
    .clk      (clk),
    .reset    (reset),
    .load     (lcnt_load),
    .dec      (lcnt_dec),
    .load_val (LCNT_INIT),
    .zero     (lcnt_zero)
  );

  mc_counter #(.W(MCNT_W)) u_mcnt (
    .clk      (clk),
    .reset    (reset),
    .load     (mcnt_load),
    .dec      (mcnt_dec),
    .load_val (MCNT_INIT),
    .zero     (mcnt_zero)
  );

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Bench for hazard_unit_mc: two instances (MEM_LAT=3/MD_LAT=4 and MEM_LAT=1/MD_LAT=8)
// share directed stimulus; a cycle-count model checks both every cycle.
module tb_hazard_unit_mc;

  localparam int MEM_LAT_T [2] = '{3, 1};
  localparam int MD_LAT_T  [2] = '{4, 8};

  typedef struct packed {
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       stall_f;
    logic       stall_d;
    logic       stall_e;
    logic       stall_m;
    logic       flush_d;
    logic       flush_e;
    logic       bubble_m;
    logic       bubble_w;
    logic       md_busy;
  } out_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       RegWriteE, RegWriteM, RegWriteW, ResultSrcE, ResultSrcM, MdStartE, PcSrcE;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;

  logic [1:0] fa [2];
  logic [1:0] fb [2];
  logic sf [2], sd [2], se [2], sm [2], fd [2], fe [2], bm [2], bw [2], mb [2];

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  bit   cmp_en = 1'b0;
  int   ld_age   [2];
  int   md_given [2];
  out_t exp_o    [2];

  hazard_unit_mc #(.REG_AW(5), .MEM_LAT(MEM_LAT_T[0]), .MD_LAT(MD_LAT_T[0])) dut_a (
    .clk(clk), .reset(reset),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .ResultSrcM(ResultSrcM), .MdStartE(MdStartE),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .PcSrcE(PcSrcE),
    .ForwardAE(fa[0]), .ForwardBE(fb[0]),
    .stallF(sf[0]), .stallD(sd[0]), .stallE(se[0]), .stallM(sm[0]),
    .FlushD(fd[0]), .FlushE(fe[0]), .BubbleM(bm[0]), .BubbleW(bw[0]), .MdBusy(mb[0])
  );

  hazard_unit_mc #(.REG_AW(5), .MEM_LAT(MEM_LAT_T[1]), .MD_LAT(MD_LAT_T[1])) dut_b (
    .clk(clk), .reset(reset),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .ResultSrcM(ResultSrcM), .MdStartE(MdStartE),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .PcSrcE(PcSrcE),
    .ForwardAE(fa[1]), .ForwardBE(fb[1]),
    .stallF(sf[1]), .stallD(sd[1]), .stallE(se[1]), .stallM(sm[1]),
    .FlushD(fd[1]), .FlushE(fe[1]), .BubbleM(bm[1]), .BubbleW(bw[1]), .MdBusy(mb[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic out_t act_of(input int i);
    act_of = {fa[i], fb[i], sf[i], sd[i], se[i], sm[i], fd[i], fe[i], bm[i], bw[i], mb[i]};
  endfunction

  function automatic logic [1:0] fwd_of(input logic [4:0] rs);
    if (RegWriteM && !ResultSrcM && rs != 5'd0 && rs == RdM) return 2'b10;
    if (RegWriteW && rs != 5'd0 && rs == RdW)                return 2'b01;
    return 2'b00;
  endfunction

  // ld_age = stall cycles a load has already spent in M; md_given = mul/div
  // stall cycles already delivered (MD_LAT means finished, waiting to leave E).
  function automatic out_t model_out(input int i);
    out_t o;
    bit   ld_s, md_s, lw_d, lw_e;
    o = '0;
    o.fwd_a = fwd_of(Rs1E);
    o.fwd_b = fwd_of(Rs2E);
    if (ld_age[i] > 0) ld_s = (ld_age[i] < MEM_LAT_T[i] - 1);
    else               ld_s = ResultSrcM && (MEM_LAT_T[i] > 1);
    if (md_given[i] > 0) md_s = (md_given[i] < MD_LAT_T[i]);
    else                 md_s = MdStartE;
    lw_d = (ResultSrcE && RegWriteE && RdE != 5'd0 && (Rs1D == RdE || Rs2D == RdE))
        || (ResultSrcM && RegWriteM && RdM != 5'd0 && (Rs1D == RdM || Rs2D == RdM));
    lw_e = ResultSrcM && RegWriteM && RdM != 5'd0 && (Rs1E == RdM || Rs2E == RdM);
    o.stall_m  = ld_s;
    o.stall_e  = ld_s || md_s || lw_e;
    o.stall_d  = o.stall_e || lw_d;
    o.stall_f  = o.stall_d;
    o.bubble_w = ld_s;
    o.bubble_m = o.stall_e && !ld_s;
    o.flush_d  = PcSrcE && !o.stall_e;
    o.flush_e  = o.flush_d || (o.stall_d && !o.stall_e);
    o.md_busy  = (md_given[i] > 0) || md_s;
    return o;
  endfunction

  task automatic model_step(input int i, input out_t o);
    if (reset) begin
      ld_age[i]   = 0;
      md_given[i] = 0;
    end else begin
      ld_age[i] = o.stall_m ? ld_age[i] + 1 : 0;
      if (md_given[i] == 0)                md_given[i] = MdStartE ? 1 : 0;
      else if (md_given[i] < MD_LAT_T[i])  md_given[i] = md_given[i] + 1;
      else if (!o.stall_e)                 md_given[i] = 0;
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      cyc++;
      for (int i = 0; i < 2; i++) begin
        exp_o[i] = model_out(i);
        check($sformatf("cycle %0d dut%0d outputs", cyc, i), 32'(act_of(i)), 32'(exp_o[i]));
      end
      for (int i = 0; i < 2; i++) model_step(i, exp_o[i]);
    end
  end

  task automatic idle();
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; ResultSrcE = 0; ResultSrcM = 0;
    MdStartE = 0; PcSrcE = 0; reset = 0;
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      ld_age[i]   = 0;
      md_given[i] = 0;
    end
    idle();
    reset = 1;
    tick(); cmp_en = 1'b1;
    tick();
    reset = 0; #2;
    check("reset outputs dut0", 32'(act_of(0)), 32'd0);
    check("reset outputs dut1", 32'(act_of(1)), 32'd0);

    // Forward priority
    tick(); RegWriteM = 1; RegWriteW = 1; RdM = 5; RdW = 5; Rs1E = 5; ResultSrcM = 0; #2;
    check("fwd M over W", 32'(fa[0]), 32'h2);
    tick(); ResultSrcM = 1; #2;
    check("fwd W when M is load", 32'(fa[0]), 32'h1);
    check("load-use in E stalls E", 32'(se[0]), 32'd1);
    tick(); tick();
    tick(); ResultSrcM = 0; Rs1E = 0; #2;
    check("fwd x0 stays RF", 32'(fa[0]), 32'h0);
    tick(); idle();

    // Load-use, MEM_LAT = 3 on dut0
    tick(); idle(); ResultSrcE = 1; RegWriteE = 1; RdE = 6; Rs1D = 6; Rs2D = 1; #2;
    check("lw in E stalls D", 32'(sd[0]), 32'd1);
    check("lw in E flushes E", 32'(fe[0]), 32'd1);
    check("lw in E keeps E", 32'(se[0]), 32'd0);
    tick(); ResultSrcE = 0; RegWriteE = 0; RdE = 0; ResultSrcM = 1; RegWriteM = 1; RdM = 6; #2;
    check("lw M cycle1 stallM", 32'(sm[0]), 32'd1);
    check("lw M cycle1 BubbleW", 32'(bw[0]), 32'd1);
    check("lw M cycle1 stallF", 32'(sf[0]), 32'd1);
    check("lw M cycle1 no FlushE", 32'(fe[0]), 32'd0);
    tick(); #2;
    check("lw M cycle2 stallM", 32'(sm[0]), 32'd1);
    tick(); #2;
    check("lw M cycle3 stallM", 32'(sm[0]), 32'd0);
    check("lw M cycle3 FlushE", 32'(fe[0]), 32'd1);
    check("lw M cycle3 stallF", 32'(sf[0]), 32'd1);
    tick(); idle(); RegWriteW = 1; RdW = 6; Rs1E = 6; Rs2E = 1; #2;
    check("add gets W forward", 32'(fa[0]), 32'h1);
    check("add no D stall", 32'(sd[0]), 32'd0);

    // Back-to-back loads, MEM_LAT = 1 on dut1
    tick(); idle(); ResultSrcM = 1; RegWriteM = 1; RdM = 3; RegWriteW = 1; RdW = 2;
    Rs1E = 3; Rs2E = 2; #2;
    check("b2b stallE", 32'(se[1]), 32'd1);
    check("b2b no stallM", 32'(sm[1]), 32'd0);
    check("b2b BubbleM", 32'(bm[1]), 32'd1);
    check("b2b fwdB from W", 32'(fb[1]), 32'h1);
    tick(); ResultSrcM = 0; RegWriteM = 0; RdM = 0; RdW = 3; #2;
    check("slt fwdA from W", 32'(fa[1]), 32'h1);
    check("slt fwdB from RF", 32'(fb[1]), 32'h0);
    check("slt no stallE", 32'(se[1]), 32'd0);
    repeat (3) begin tick(); idle(); end

    // Mul/div, MD_LAT = 4 on dut0, with branches
    tick(); idle(); MdStartE = 1; #2;
    check("md start stallE", 32'(se[0]), 32'd1);
    check("md start BubbleM", 32'(bm[0]), 32'd1);
    check("md start MdBusy", 32'(mb[0]), 32'd1);
    tick(); PcSrcE = 1; #2;
    check("branch in md stall FlushD", 32'(fd[0]), 32'd0);
    check("branch in md stall FlushE", 32'(fe[0]), 32'd0);
    tick(); PcSrcE = 0; #2;
    tick(); #2;
    check("md 4th stall cycle", 32'(se[0]), 32'd1);
    tick(); PcSrcE = 1; #2;
    check("md done no stallE", 32'(se[0]), 32'd0);
    check("md done MdBusy", 32'(mb[0]), 32'd1);
    check("branch taken FlushD", 32'(fd[0]), 32'd1);
    check("branch taken FlushE", 32'(fe[0]), 32'd1);
    tick(); MdStartE = 0; PcSrcE = 0; #2;
    check("md back to idle", 32'(mb[0]), 32'd0);
    repeat (6) begin tick(); idle(); end

    // Reset during BUSY, MD_LAT = 8 on dut1
    tick(); MdStartE = 1;
    tick();
    tick(); reset = 1; #2;
    check("3rd md stall under reset", 32'(se[1]), 32'd1);
    tick(); reset = 0; MdStartE = 0; #2;
    check("reset aborts md MdBusy", 32'(mb[1]), 32'd0);
    check("reset aborts md outputs", 32'(act_of(1)), 32'd0);

    // Mixed vectors, checked by the per-cycle model only
    repeat (64) begin
      tick();
      RegWriteE  = 1'($urandom_range(0, 1)); RegWriteM = 1'($urandom_range(0, 1));
      RegWriteW  = 1'($urandom_range(0, 1)); ResultSrcE = 1'($urandom_range(0, 1));
      ResultSrcM = 1'($urandom_range(0, 1)); MdStartE  = ($urandom_range(0, 5) == 0);
      PcSrcE     = 1'($urandom_range(0, 1)); reset     = ($urandom_range(0, 19) == 0);
      Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
      Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
      RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
      RdW  = 5'($urandom_range(0, 3));
    end
    tick(); idle();
    tick();
    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
